// File: rtl/fetch_pc_gen_if.sv
// Fetch PC generator bus: stall/redirect inputs and fetch PC/flush outputs.
// The master side drives requests; the slave side is the PC generator.
interface fetch_pc_gen_if #(
   parameter int N = 32
);
   logic         stall;
   logic         br_taken;
   logic [N-1:0] br_target;
   logic         jmp_taken;
   logic [N-1:0] jmp_target;
   logic [N-1:0] pc;
   logic         pc_valid;
   logic         flush_en;
   logic [N-1:0] flush_pc;
   logic         misalign_err;

   modport master (
      output stall, br_taken, br_target, jmp_taken, jmp_target,
      input  pc, pc_valid, flush_en, flush_pc, misalign_err
   );

   modport slave (
      input  stall, br_taken, br_target, jmp_taken, jmp_target,
      output pc, pc_valid, flush_en, flush_pc, misalign_err
   );
endinterface

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: sequential PC, redirect arbitration and stall-pending.
// Optional target alignment check under macro PC_ALIGN_CHECK_EN.
module fetch_pc_gen #(
   parameter int           N        = 32,
   parameter logic [N-1:0] RESET_PC = '0
) (
   input  logic           clk,
   input  logic           rst_n,
   fetch_pc_gen_if.slave  bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_t;

   state_t       state;
   logic [N-1:0] pc_q;
   logic         valid_q;
   logic         flush_q;
   logic [N-1:0] flush_pc_q;
   logic         err_q;
   logic [N-1:0] pend_target;
   logic         pend_is_br;

   logic         req;
   logic [N-1:0] run_t;
   logic [N-1:0] pend_t;

   function automatic logic [N-1:0] align(input logic [N-1:0] t);
`ifdef PC_ALIGN_CHECK_EN
      return {t[N-1:2], 2'b00};
`else
      return t;
`endif
   endfunction

   function automatic logic misal(input logic [N-1:0] t);
`ifdef PC_ALIGN_CHECK_EN
      return |t[1:0];
`else
      return 1'b0 & t[0];
`endif
   endfunction

   assign req   = bus.br_taken | bus.jmp_taken;
   assign run_t = bus.br_taken ? bus.br_target : bus.jmp_target;

   // A held branch outranks a fresh jump; a fresh branch outranks all.
   always_comb begin
      pend_t = pend_target;
      if (bus.br_taken)
         pend_t = bus.br_target;
      else if (pend_is_br)
         pend_t = pend_target;
      else if (bus.jmp_taken)
         pend_t = bus.jmp_target;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         pc_q        <= RESET_PC;
         valid_q     <= 1'b0;
         flush_q     <= 1'b0;
         flush_pc_q  <= RESET_PC;
         err_q       <= 1'b0;
         pend_target <= '0;
         pend_is_br  <= 1'b0;
      end else begin
         flush_q <= 1'b0;
         err_q   <= 1'b0;
         unique case (state)
            IDLE: begin
               state   <= RUN;
               valid_q <= 1'b1;
            end
            RUN: begin
               if (req && bus.stall) begin
                  pend_target <= run_t;
                  pend_is_br  <= bus.br_taken;
                  state       <= PEND;
               end else if (req) begin
                  pc_q       <= align(run_t);
                  flush_pc_q <= align(run_t);
                  flush_q    <= 1'b1;
                  err_q      <= misal(run_t);
               end else if (!bus.stall) begin
                  pc_q <= pc_q + N'(4);
               end
            end
            PEND: begin
               if (bus.stall) begin
                  if (bus.br_taken) begin
                     pend_target <= bus.br_target;
                     pend_is_br  <= 1'b1;
                  end else if (bus.jmp_taken && !pend_is_br) begin
                     pend_target <= bus.jmp_target;
                     pend_is_br  <= 1'b0;
                  end
               end else begin
                  pc_q       <= align(pend_t);
                  flush_pc_q <= align(pend_t);
                  flush_q    <= 1'b1;
                  err_q      <= misal(pend_t);
                  state      <= RUN;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.pc           = pc_q;
   assign bus.pc_valid     = valid_q;
   assign bus.flush_en     = flush_q;
   assign bus.flush_pc     = flush_pc_q;
   assign bus.misalign_err = err_q;
endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen: two instances with different RESET_PC.
// Outputs are sampled 1ns after each rising edge.
module tb_fetch_pc_gen;
   logic clk = 1'b0;
   logic rst_a;
   logic rst_b;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   fetch_pc_gen_if #(.N(32)) bus_a ();
   fetch_pc_gen_if #(.N(32)) bus_b ();

   fetch_pc_gen #(.N(32), .RESET_PC(32'h0000_1000)) dut_a (
      .clk   (clk),
      .rst_n (rst_a),
      .bus   (bus_a)
   );

   fetch_pc_gen #(.N(32), .RESET_PC(32'hFFFF_FFF8)) dut_b (
      .clk   (clk),
      .rst_n (rst_b),
      .bus   (bus_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_a();
      bus_a.stall      = 1'b0;
      bus_a.br_taken   = 1'b0;
      bus_a.br_target  = '0;
      bus_a.jmp_taken  = 1'b0;
      bus_a.jmp_target = '0;
   endtask

   task automatic test_reset();
      logic [31:0] exp_pc [3];
      exp_pc[0] = 32'h1000;
      exp_pc[1] = 32'h1004;
      exp_pc[2] = 32'h1008;
      idle_a();
      rst_a = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_cmp++;
         if (bus_a.pc !== 32'h1000 || bus_a.pc_valid !== 1'b0 ||
             bus_a.flush_en !== 1'b0 || bus_a.flush_pc !== 32'h1000 ||
             bus_a.misalign_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state cyc%0d: pc=%h v=%b f=%b fpc=%h e=%b want 1000/0/0/1000/0",
                     i, bus_a.pc, bus_a.pc_valid, bus_a.flush_en,
                     bus_a.flush_pc, bus_a.misalign_err);
         end
      end
      rst_a = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if (bus_a.pc !== exp_pc[i] || bus_a.pc_valid !== 1'b1 ||
             bus_a.flush_en !== 1'b0) begin
            n_err++;
            $display("FAIL seq_pc%0d: pc=%h v=%b f=%b want %h/1/0",
                     i, bus_a.pc, bus_a.pc_valid, bus_a.flush_en, exp_pc[i]);
         end
      end
   endtask

   task automatic test_branch();
      bus_a.br_taken  = 1'b1;
      bus_a.br_target = 32'h2000;
      tick();
      n_cmp++;
      if (bus_a.pc !== 32'h2000 || bus_a.flush_en !== 1'b1 ||
          bus_a.flush_pc !== 32'h2000) begin
         n_err++;
         $display("FAIL br_redirect: pc=%h f=%b fpc=%h want 2000/1/2000",
                  bus_a.pc, bus_a.flush_en, bus_a.flush_pc);
      end
      idle_a();
      tick();
      n_cmp++;
      if (bus_a.pc !== 32'h2004 || bus_a.flush_en !== 1'b0) begin
         n_err++;
         $display("FAIL br_resume: pc=%h f=%b want 2004/0",
                  bus_a.pc, bus_a.flush_en);
      end
   endtask

   task automatic test_back_to_back();
      bus_a.br_taken   = 1'b1;
      bus_a.br_target  = 32'h3000;
      bus_a.jmp_taken  = 1'b1;
      bus_a.jmp_target = 32'h4000;
      tick();
      n_cmp++;
      if (bus_a.pc !== 32'h3000 || bus_a.flush_en !== 1'b1 ||
          bus_a.flush_pc !== 32'h3000) begin
         n_err++;
         $display("FAIL br_vs_jmp: pc=%h f=%b fpc=%h want 3000/1/3000",
                  bus_a.pc, bus_a.flush_en, bus_a.flush_pc);
      end
      idle_a();
      tick();
      n_cmp++;
      if (bus_a.pc !== 32'h3004 || bus_a.flush_en !== 1'b0) begin
         n_err++;
         $display("FAIL br_vs_jmp_after: pc=%h f=%b want 3004/0",
                  bus_a.pc, bus_a.flush_en);
      end
   endtask

   task automatic test_stall_run();
      bus_a.stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_cmp++;
         if (bus_a.pc !== 32'h3004 || bus_a.pc_valid !== 1'b1 ||
             bus_a.flush_en !== 1'b0) begin
            n_err++;
            $display("FAIL stall_hold%0d: pc=%h v=%b f=%b want 3004/1/0",
                     i, bus_a.pc, bus_a.pc_valid, bus_a.flush_en);
         end
      end
      bus_a.stall = 1'b0;
      tick();
      n_cmp++;
      if (bus_a.pc !== 32'h3008) begin
         n_err++;
         $display("FAIL stall_release: pc=%h want 3008", bus_a.pc);
      end
   endtask

   task automatic test_stall_pend();
      logic        tk_b [4];
      logic        tk_j [4];
      logic [31:0] tg   [4];
      tk_b[0] = 0; tk_j[0] = 1; tg[0] = 32'h5000;
      tk_b[1] = 1; tk_j[1] = 0; tg[1] = 32'h6000;
      tk_b[2] = 0; tk_j[2] = 1; tg[2] = 32'h7000;
      tk_b[3] = 0; tk_j[3] = 0; tg[3] = 32'h0;
      for (int i = 0; i < 4; i++) begin
         bus_a.stall      = 1'b1;
         bus_a.br_taken   = tk_b[i];
         bus_a.br_target  = tg[i];
         bus_a.jmp_taken  = tk_j[i];
         bus_a.jmp_target = tg[i];
         tick();
         n_cmp++;
         if (bus_a.pc !== 32'h3008 || bus_a.flush_en !== 1'b0) begin
            n_err++;
            $display("FAIL pend_hold%0d: pc=%h f=%b want 3008/0",
                     i, bus_a.pc, bus_a.flush_en);
         end
      end
      idle_a();
      tick();
      n_cmp++;
      if (bus_a.pc !== 32'h6000 || bus_a.flush_en !== 1'b1 ||
          bus_a.flush_pc !== 32'h6000) begin
         n_err++;
         $display("FAIL pend_apply: pc=%h f=%b fpc=%h want 6000/1/6000",
                  bus_a.pc, bus_a.flush_en, bus_a.flush_pc);
      end
      tick();
      n_cmp++;
      if (bus_a.pc !== 32'h6004 || bus_a.flush_en !== 1'b0) begin
         n_err++;
         $display("FAIL pend_resume: pc=%h f=%b want 6004/0",
                  bus_a.pc, bus_a.flush_en);
      end
   endtask

   task automatic test_reset_in_pend();
      bus_a.stall     = 1'b1;
      bus_a.br_taken  = 1'b1;
      bus_a.br_target = 32'h6000;
      tick();
      bus_a.br_taken = 1'b0;
      rst_a = 1'b0;
      tick();
      n_cmp++;
      if (bus_a.pc !== 32'h1000 || bus_a.pc_valid !== 1'b0 ||
          bus_a.flush_en !== 1'b0) begin
         n_err++;
         $display("FAIL pend_reset: pc=%h v=%b f=%b want 1000/0/0",
                  bus_a.pc, bus_a.pc_valid, bus_a.flush_en);
      end
      rst_a = 1'b1;
      idle_a();
      tick();
      n_cmp++;
      if (bus_a.pc !== 32'h1000 || bus_a.pc_valid !== 1'b1 ||
          bus_a.flush_en !== 1'b0) begin
         n_err++;
         $display("FAIL pend_reset_rel: pc=%h v=%b f=%b want 1000/1/0",
                  bus_a.pc, bus_a.pc_valid, bus_a.flush_en);
      end
      tick();
      n_cmp++;
      if (bus_a.pc !== 32'h1004 || bus_a.flush_en !== 1'b0) begin
         n_err++;
         $display("FAIL pend_reset_run: pc=%h f=%b want 1004/0",
                  bus_a.pc, bus_a.flush_en);
      end
   endtask

   task automatic test_misalign();
      logic [31:0] exp_t;
      logic        exp_e;
`ifdef PC_ALIGN_CHECK_EN
      exp_t = 32'h2000;
      exp_e = 1'b1;
`else
      exp_t = 32'h2002;
      exp_e = 1'b0;
`endif
      bus_a.br_taken  = 1'b1;
      bus_a.br_target = 32'h2002;
      tick();
      n_cmp++;
      if (bus_a.pc !== exp_t || bus_a.flush_pc !== exp_t ||
          bus_a.flush_en !== 1'b1 || bus_a.misalign_err !== exp_e) begin
         n_err++;
         $display("FAIL misalign: pc=%h fpc=%h f=%b e=%b want %h/%h/1/%b",
                  bus_a.pc, bus_a.flush_pc, bus_a.flush_en,
                  bus_a.misalign_err, exp_t, exp_t, exp_e);
      end
      idle_a();
      tick();
      n_cmp++;
      if (bus_a.pc !== exp_t + 32'd4 || bus_a.misalign_err !== 1'b0 ||
          bus_a.flush_en !== 1'b0) begin
         n_err++;
         $display("FAIL misalign_after: pc=%h e=%b f=%b want %h/0/0",
                  bus_a.pc, bus_a.misalign_err, bus_a.flush_en,
                  exp_t + 32'd4);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_pc [4];
      exp_pc[0] = 32'hFFFF_FFF8;
      exp_pc[1] = 32'hFFFF_FFFC;
      exp_pc[2] = 32'h0000_0000;
      exp_pc[3] = 32'h0000_0004;
      n_cmp++;
      if (bus_b.pc !== 32'hFFFF_FFF8 || bus_b.pc_valid !== 1'b0) begin
         n_err++;
         $display("FAIL wrap_reset: pc=%h v=%b want fffffff8/0",
                  bus_b.pc, bus_b.pc_valid);
      end
      rst_b = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++;
         if (bus_b.pc !== exp_pc[i] || bus_b.pc_valid !== 1'b1 ||
             bus_b.misalign_err !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_pc%0d: pc=%h v=%b e=%b want %h/1/0",
                     i, bus_b.pc, bus_b.pc_valid, bus_b.misalign_err,
                     exp_pc[i]);
         end
      end
   endtask

   initial begin
      rst_a = 1'b0;
      rst_b = 1'b0;
      bus_b.stall      = 1'b0;
      bus_b.br_taken   = 1'b0;
      bus_b.br_target  = '0;
      bus_b.jmp_taken  = 1'b0;
      bus_b.jmp_target = '0;
      idle_a();
      test_reset();
      test_branch();
      test_back_to_back();
      test_stall_run();
      test_stall_pend();
      test_reset_in_pend();
      test_misalign();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
